// File: rtl/fnd_arb_pkg.sv
// fnd_arb_pkg: shared state encoding, select-width helper and default timing for the FND arbiter
package fnd_arb_pkg;
  typedef enum logic {ST_AUTO = 1'b0, ST_MANUAL = 1'b1} state_t;
  localparam int DEF_NUM_SRC       = 3;
  localparam int DEF_DATA_W        = 12;
  localparam int DEF_TICK_DIV      = 100_000;
  localparam int DEF_ROTATE_TICKS  = 3000;
  localparam int DEF_REFRESH_TICKS = 250;
  function automatic int f_sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fnd_tick_gen.sv
// fnd_tick_gen: free-running divider emitting a one-cycle tick every TICK_DIV clocks
module fnd_tick_gen #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] r_cnt;
  assign o_tick = (r_cnt == CW'(TICK_DIV - 1));
  // Count 0..TICK_DIV-1 and wrap on the terminal count
  always_ff @(posedge clk)
    if (!reset) r_cnt <= '0;
    else        r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/fnd_display_arbiter.sv
// fnd_display_arbiter: shares one 4-digit FND between sensor sources with auto/manual selection
module fnd_display_arbiter
  import fnd_arb_pkg::*;
#(
  parameter  int NUM_SRC       = DEF_NUM_SRC,
  parameter  int DATA_W        = DEF_DATA_W,
  parameter  int TICK_DIV      = DEF_TICK_DIV,
  parameter  int ROTATE_TICKS  = DEF_ROTATE_TICKS,
  parameter  int REFRESH_TICKS = DEF_REFRESH_TICKS,
  localparam int SEL_W         = f_sel_w(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        i_src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
  input  logic                      i_btn_next,
  input  logic                      i_btn_mode,
  output logic [DATA_W-1:0]         o_fnd_data,
  output logic [SEL_W-1:0]          o_src_sel,
  output logic                      o_auto,
  output logic                      o_no_data
);
  localparam int RW = $clog2(ROTATE_TICKS + 1);
  localparam int FW = $clog2(REFRESH_TICKS + 1);
  state_t              r_state, w_state_nxt;
  logic                w_tick;
  logic [SEL_W-1:0]    r_sel, w_sel_nxt, w_sel_skip, w_sel_inc;
  logic [RW-1:0]       r_rot, w_rot_nxt;
  logic [FW-1:0]       r_ref;
  logic [NUM_SRC-1:0]  r_has;
  logic [DATA_W-1:0]   r_shadow [NUM_SRC];
  logic [DATA_W-1:0]   r_fnd;
  logic                w_rot_done, w_ref_done;

  // First source after sel (wrapping) that has delivered data; sel itself if none
  function automatic logic [SEL_W-1:0] f_next_src(input logic [SEL_W-1:0] sel,
                                                  input logic [NUM_SRC-1:0] has);
    logic [SEL_W-1:0] res;
    logic             found;
    int               idx;
    res   = sel;
    found = 1'b0;
    for (int i = 1; i < NUM_SRC; i++) begin
      idx = (int'(sel) + i) % NUM_SRC;
      if (!found && |(has & (NUM_SRC'(1) << idx))) begin
        res   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  fnd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .o_tick(w_tick)
  );

  assign w_sel_skip = f_next_src(r_sel, r_has);
  assign w_sel_inc  = (r_sel == SEL_W'(NUM_SRC - 1)) ? '0 : r_sel + 1'b1;
  assign w_rot_done = (r_rot == RW'(ROTATE_TICKS - 1));
  assign w_ref_done = (r_ref == FW'(REFRESH_TICKS - 1));

  // Next state, selection and rotate timer; mode beats next, next beats timed rotation
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rot_nxt   = r_rot;
    if (i_btn_mode) begin
      w_state_nxt = (r_state == ST_AUTO) ? ST_MANUAL : ST_AUTO;
      w_rot_nxt   = '0;
    end else if (i_btn_next) begin
      w_sel_nxt = (r_state == ST_AUTO) ? w_sel_skip : w_sel_inc;
      w_rot_nxt = '0;
    end else if (r_state == ST_AUTO && w_tick) begin
      w_sel_nxt = w_rot_done ? w_sel_skip : r_sel;
      w_rot_nxt = w_rot_done ? '0 : r_rot + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk)
    if (!reset) r_state <= ST_AUTO;
    else        r_state <= w_state_nxt;

  // Selection, rotate timer and rate-limited display value; a sel change reloads at once
  always_ff @(posedge clk)
    if (!reset) begin
      r_sel <= '0;
      r_rot <= '0;
      r_ref <= '0;
      r_fnd <= '0;
    end else begin
      r_sel <= w_sel_nxt;
      r_rot <= w_rot_nxt;
      if (w_sel_nxt != r_sel) begin
        r_ref <= '0;
        r_fnd <= r_shadow[w_sel_nxt];
      end else if (w_tick) begin
        r_ref <= w_ref_done ? '0 : r_ref + 1'b1;
        if (w_ref_done) r_fnd <= r_shadow[r_sel];
      end
    end

  // Independent per-source snapshot of the latest sample
  always_ff @(posedge clk)
    if (!reset) begin
      r_has <= '0;
      for (int k = 0; k < NUM_SRC; k++) r_shadow[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++)
        if (i_src_valid[k]) begin
          r_shadow[k] <= i_src_data[k*DATA_W +: DATA_W];
          r_has[k]    <= 1'b1;
        end
    end

  assign o_src_sel  = r_sel;
  assign o_auto     = (r_state == ST_AUTO);
  assign o_no_data  = ~r_has[r_sel];
  assign o_fnd_data = o_no_data ? '0 : r_fnd;
endmodule

// File: tb/tb_fnd_display_arbiter.sv
// tb_fnd_display_arbiter: directed stimulus checked against a cycle-level behavioural model
module tb_fnd_display_arbiter;
  localparam int NS = 3, DW = 12, TD = 10, RT = 4, RF = 2;
  logic            clk = 1'b0, reset = 1'b0;
  logic [NS-1:0]   valid = '0;
  logic [NS*DW-1:0] data = '0;
  logic            btn_next = 1'b0, btn_mode = 1'b0;
  logic [DW-1:0]   fnd;
  logic [1:0]      sel;
  logic            auto_o, no_data;
  int checks = 0, failures = 0;
  bit chk_en = 1'b0;
  int m_tc = 0, m_rot = 0, m_ref = 0, m_sel = 0, m_disp = 0, m_auto = 1;
  int m_has [NS];
  int m_shadow [NS];
  int n;

  fnd_display_arbiter #(
    .NUM_SRC(NS), .DATA_W(DW), .TICK_DIV(TD), .ROTATE_TICKS(RT), .REFRESH_TICKS(RF)
  ) dut (
    .clk(clk), .reset(reset), .i_src_valid(valid), .i_src_data(data),
    .i_btn_next(btn_next), .i_btn_mode(btn_mode),
    .o_fnd_data(fnd), .o_src_sel(sel), .o_auto(auto_o), .o_no_data(no_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int skip_next(input int s);
    for (int i = 1; i < NS; i++) if (m_has[(s + i) % NS] != 0) return (s + i) % NS;
    return s;
  endfunction

  always @(posedge clk) begin : model
    bit tick;
    int ns;
    if (!reset) begin
      m_tc = 0; m_rot = 0; m_ref = 0; m_sel = 0; m_disp = 0; m_auto = 1;
      for (int k = 0; k < NS; k++) begin m_has[k] = 0; m_shadow[k] = 0; end
    end else begin
      tick = (m_tc == TD - 1);
      m_tc = (m_tc + 1) % TD;
      ns = m_sel;
      if (btn_mode) begin
        m_auto = 1 - m_auto;
        m_rot = 0;
      end else if (btn_next) begin
        ns = (m_auto != 0) ? skip_next(m_sel) : (m_sel + 1) % NS;
        m_rot = 0;
      end else if (m_auto != 0 && tick) begin
        m_rot++;
        if (m_rot == RT) begin ns = skip_next(m_sel); m_rot = 0; end
      end
      if (ns != m_sel) begin
        m_disp = m_shadow[ns];
        m_ref = 0;
      end else if (tick) begin
        m_ref++;
        if (m_ref == RF) begin m_disp = m_shadow[m_sel]; m_ref = 0; end
      end
      for (int k = 0; k < NS; k++)
        if (valid[k]) begin m_shadow[k] = int'(data[k*DW +: DW]); m_has[k] = 1; end
      m_sel = ns;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sel", int'(sel), m_sel);
      check("auto", int'(auto_o), m_auto);
      check("no_data", int'(no_data), (m_has[m_sel] != 0) ? 0 : 1);
      check("fnd", int'(fnd), (m_has[m_sel] != 0) ? m_disp : 0);
    end
  end

  task automatic pulse_mode(); btn_mode = 1'b1; @(negedge clk); btn_mode = 1'b0; endtask
  task automatic pulse_next(); btn_next = 1'b1; @(negedge clk); btn_next = 1'b0; endtask
  task automatic capture(input int k, input int v);
    data[k*DW +: DW] = DW'(v);
    valid[k] = 1'b1;
    @(negedge clk);
    valid = '0;
  endtask
  task automatic wait_sel(input int target, input int budget, output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (int'(sel) != target && cnt < budget);
    check("wait_sel", int'(sel), target);
  endtask
  task automatic wait_fnd(input int target, input int budget, output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (int'(fnd) != target && cnt < budget);
    check("wait_fnd", int'(fnd), target);
  endtask

  initial begin
    reset = 1'b0;
    valid = '1;
    data  = {3{12'hABC}};
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_fnd", int'(fnd), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_auto", int'(auto_o), 1);
    check("rst_no_data", int'(no_data), 1);
    reset = 1'b1;
    valid = '0;
    @(negedge clk);
    check("rel_no_capture", int'(no_data), 1);
    data[0 +: DW]  = 12'd1234;
    data[DW +: DW] = 12'd567;
    valid = 3'b011;
    @(negedge clk);
    valid = '0;
    wait_sel(1, 60, n);
    check("rot1_fnd", int'(fnd), 567);
    wait_sel(0, 60, n);
    check("rot2_cycles", n, 40);
    check("rot2_fnd", int'(fnd), 1234);
    capture(0, 99);
    check("no_bypass_fnd", int'(fnd), 1234);
    wait_fnd(99, 20, n);
    check("refresh_sel", int'(sel), 0);
    pulse_mode();
    check("manual_auto", int'(auto_o), 0);
    pulse_next();
    check("man_sel1", int'(sel), 1);
    pulse_next();
    check("man_sel2", int'(sel), 2);
    check("man_sel2_no_data", int'(no_data), 1);
    check("man_sel2_fnd", int'(fnd), 0);
    pulse_next();
    check("man_wrap", int'(sel), 0);
    repeat (200) @(negedge clk);
    check("man_idle_sel", int'(sel), 0);
    pulse_mode();
    check("back_auto", int'(auto_o), 1);
    btn_mode = 1'b1;
    btn_next = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_next = 1'b0;
    check("both_auto", int'(auto_o), 0);
    check("both_sel", int'(sel), 0);
    n = 0;
    while (m_tc != TD - 1 && n < TD) begin @(negedge clk); n++; end
    pulse_mode();
    check("realign_auto", int'(auto_o), 1);
    wait_sel(1, 60, n);
    check("rot_clear_cycles", n, 40);
    capture(2, 4095);
    pulse_mode();
    check("man2_auto", int'(auto_o), 0);
    pulse_next();
    check("man2_sel", int'(sel), 2);
    check("man2_fnd", int'(fnd), 4095);
    check("man2_no_data", int'(no_data), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_auto", int'(auto_o), 1);
    check("rst2_sel", int'(sel), 0);
    check("rst2_fnd", int'(fnd), 0);
    check("rst2_no_data", int'(no_data), 1);
    reset = 1'b1;
    pulse_next();
    check("empty_next_sel", int'(sel), 0);
    check("empty_no_data", int'(no_data), 1);
    @(negedge clk);
    chk_en = 1'b0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
